// File: rtl/ccc_lock_reset_seq_pkg.sv
// ---------------------------------------------------------------------------
// ccc_rst_pkg
//
// Shared types and constants for the CCC lock-qualified fabric reset
// sequencer (ccc_lock_reset_seq) and its lock synchronizer (lock_sync).
//
// Contents:
//   state_t              sequencer FSM state encoding
//   DEF_*                default values for the top-level parameters
//   CNT_W                width of the qualification / release-gap counter
//   LOSS_CNT_W           width of the lock-loss event counter
//   LOSS_CNT_SAT         value at which the lock-loss counter saturates
//   loss_cnt_sat_inc()   saturating increment for the lock-loss counter
// ---------------------------------------------------------------------------
package ccc_rst_pkg;

    // Sequencer states. The encoding is fixed so that the state register
    // reads back as a stable 2-bit code in netlists and debug probes.
    typedef enum logic [1:0] {
        S_WAIT     = 2'd0,  // all resets asserted, waiting for lock
        S_QUAL     = 2'd1,  // lock present, counting the stable period
        S_REL_CORE = 2'd2,  // core released, counting the release gap
        S_RUN      = 2'd3   // core and peripheral logic both released
    } state_t;

    // Default parameter values.
    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_RELEASE_GAP        = 64;
    localparam bit DEF_REQUIRE_MSS_LOCK   = 1'b1;

    // The shared counter must hold LOCK_STABLE_CYCLES-1 and RELEASE_GAP-1,
    // both of which are at most 65534.
    localparam int CNT_W = 16;

    // Lock-loss event counter.
    localparam int                    LOSS_CNT_W   = 8;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_SAT = 8'd255;

    // Increment that sticks at LOSS_CNT_SAT instead of wrapping to zero, so
    // software never mistakes a storm of lock losses for a quiet system.
    function automatic logic [LOSS_CNT_W-1:0] loss_cnt_sat_inc(
        input logic [LOSS_CNT_W-1:0] i_val
    );
        if (i_val == LOSS_CNT_SAT) begin
            return i_val;
        end
        return i_val + LOSS_CNT_W'(1);
    endfunction

endpackage : ccc_rst_pkg

// File: rtl/ccc_lock_reset_seq_lock_sync.sv
// ---------------------------------------------------------------------------
// lock_sync
//
// Two-flop synchronizer that brings an asynchronous CCC lock level into the
// fabric clock domain. Both flops clear to 0 under reset, so a lock is never
// reported until it has been sampled twice after reset release.
//
// Ports:
//   i_clk     in  1  destination clock
//   i_rst_n   in  1  synchronous active-low reset
//   i_async   in  1  asynchronous level to synchronize
//   o_sync    out 1  synchronized level, two i_clk edges behind i_async
// ---------------------------------------------------------------------------
module lock_sync
    import ccc_rst_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;   // first stage, may go metastable
    logic r_sync;   // second stage, safe to fan out

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make both flops sample their
            // inputs at the same edge; blocking ones here would collapse
            // the two stages into one.
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule : lock_sync

// File: rtl/ccc_lock_reset_seq.sv
// ---------------------------------------------------------------------------
// ccc_lock_reset_seq
//
// Fabric reset sequencer sitting directly behind the MSS clock conditioning
// circuit. The CCC lock outputs are synchronized, combined into lock_ok and
// qualified for LOCK_STABLE_CYCLES consecutive cycles. Core logic is then
// released, followed RELEASE_GAP cycles later by the peripheral / CC3000
// interface logic. Any drop of lock_ok after core release is a lock-loss
// event: both resets re-assert, a sticky flag is set and a saturating event
// counter increments. A drop during qualification simply restarts it.
//
// Parameters:
//   LOCK_STABLE_CYCLES  1..65535  qualified-lock cycles before core release
//   RELEASE_GAP         1..65535  cycles from core release to periph release
//   REQUIRE_MSS_LOCK    1: lock_ok = FAB_LOCK & MSS_LOCK, 0: FAB_LOCK only
//
// Ports:
//   FAB_CLK         in  1  fabric clock, the only clock
//   M2F_RESET_N     in  1  synchronous active-low reset
//   FAB_LOCK        in  1  CCC fabric PLL lock, asynchronous
//   MSS_LOCK        in  1  CCC MSS PLL lock, asynchronous
//   LOSS_CLR        in  1  one-cycle pulse, clears LOCK_LOST and LOSS_COUNT
//   CORE_RESET_N    out 1  active-low reset for core fabric logic
//   PERIPH_RESET_N  out 1  active-low reset for peripheral logic
//   CLK_READY       out 1  high when both resets are released
//   LOCK_LOST       out 1  sticky: lock dropped after core release
//   LOSS_COUNT      out 8  saturating count of lock-loss events
//
// Latency, with E0 the edge at which the first synchronizer stage captures
// lock_ok=1: S_QUAL at E0+2, CORE_RESET_N high at E0+LOCK_STABLE_CYCLES+2,
// PERIPH_RESET_N / CLK_READY high at E0+LOCK_STABLE_CYCLES+RELEASE_GAP+2.
// A loss first captured at L0 is visible on every output at L0+2.
// ---------------------------------------------------------------------------
module ccc_lock_reset_seq
    import ccc_rst_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int RELEASE_GAP        = DEF_RELEASE_GAP,
    parameter bit REQUIRE_MSS_LOCK   = DEF_REQUIRE_MSS_LOCK
) (
    input  logic                  FAB_CLK,
    input  logic                  M2F_RESET_N,
    input  logic                  FAB_LOCK,
    input  logic                  MSS_LOCK,
    input  logic                  LOSS_CLR,
    output logic                  CORE_RESET_N,
    output logic                  PERIPH_RESET_N,
    output logic                  CLK_READY,
    output logic                  LOCK_LOST,
    output logic [LOSS_CNT_W-1:0] LOSS_COUNT
);

    // Terminal counts: the counter runs 0..N-1, so N cycles are spent in
    // the counting state before the transition is taken.
    localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(RELEASE_GAP - 1);

    // -----------------------------------------------------------------------
    // Lock synchronization
    // -----------------------------------------------------------------------
    logic w_fab_s;
    logic w_mss_s;
    logic w_lock_ok;

    lock_sync u_fab_sync (
        .i_clk   (FAB_CLK),
        .i_rst_n (M2F_RESET_N),
        .i_async (FAB_LOCK),
        .o_sync  (w_fab_s)
    );

    lock_sync u_mss_sync (
        .i_clk   (FAB_CLK),
        .i_rst_n (M2F_RESET_N),
        .i_async (MSS_LOCK),
        .o_sync  (w_mss_s)
    );

    // With REQUIRE_MSS_LOCK=0 the MSS term is forced true and its
    // synchronizer output is ignored.
    assign w_lock_ok = w_fab_s & (w_mss_s | ~REQUIRE_MSS_LOCK);

    // -----------------------------------------------------------------------
    // Sequencer state
    // -----------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_loss;       // lock-loss event this cycle

    always_comb begin
        // NOTE: every signal written here gets a default before the case, so
        // no path leaves one unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_loss      = 1'b0;

        case (r_state)
            S_WAIT: begin
                w_cnt_nxt = '0;
                if (w_lock_ok) begin
                    w_state_nxt = S_QUAL;
                end
            end

            S_QUAL: begin
                // A glitch during qualification is not a loss event; it
                // just throws away the partial stable period.
                if (!w_lock_ok) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == QUAL_LAST) begin
                    w_state_nxt = S_REL_CORE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_REL_CORE: begin
                if (!w_lock_ok) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                    w_loss      = 1'b1;
                end else if (r_cnt == GAP_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_RUN: begin
                if (!w_lock_ok) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                    w_loss      = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registered state and outputs
    // -----------------------------------------------------------------------
    logic                  r_core_rst_n;
    logic                  r_run;          // drives PERIPH_RESET_N and CLK_READY
    logic                  r_lock_lost;
    logic [LOSS_CNT_W-1:0] r_loss_count;

    always_ff @(posedge FAB_CLK) begin
        if (!M2F_RESET_N) begin
            r_state      <= S_WAIT;
            r_cnt        <= '0;
            r_core_rst_n <= 1'b0;
            r_run        <= 1'b0;
            r_lock_lost  <= 1'b0;
            r_loss_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;

            // Resets are decoded from the next state so they change on the
            // same edge as the state register, glitch-free.
            r_core_rst_n <= (w_state_nxt == S_REL_CORE) || (w_state_nxt == S_RUN);
            r_run        <= (w_state_nxt == S_RUN);

            // A clear coinciding with a loss event is applied first, so the
            // event still registers: flag set, counter restarts at 1.
            if (w_loss) begin
                r_lock_lost  <= 1'b1;
                r_loss_count <= LOSS_CLR ? LOSS_CNT_W'(1)
                                         : loss_cnt_sat_inc(r_loss_count);
            end else if (LOSS_CLR) begin
                r_lock_lost  <= 1'b0;
                r_loss_count <= '0;
            end
        end
    end

    assign CORE_RESET_N   = r_core_rst_n;
    assign PERIPH_RESET_N = r_run;
    assign CLK_READY      = r_run;
    assign LOCK_LOST      = r_lock_lost;
    assign LOSS_COUNT     = r_loss_count;

endmodule : ccc_lock_reset_seq

// File: tb/tb_ccc_lock_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_ccc_lock_reset_seq
//
// Two sequencers share one set of stimulus: dut_a (LOCK_STABLE_CYCLES=16,
// RELEASE_GAP=8, MSS lock required) and dut_b (same timing, FAB_LOCK only).
// Inputs change 1 time unit after a rising edge and outputs are sampled at
// the same point, so "tick(n)" advances exactly n edges.
// ---------------------------------------------------------------------------
module tb_ccc_lock_reset_seq;

    logic       FAB_CLK = 1'b0;
    logic       rst_n;
    logic       fab_lock;
    logic       mss_lock;
    logic       loss_clr;

    logic       a_core, a_periph, a_ready, a_lost;
    logic [7:0] a_cnt;
    logic       b_core, b_periph, b_ready, b_lost;
    logic [7:0] b_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 FAB_CLK = ~FAB_CLK;

    ccc_lock_reset_seq #(
        .LOCK_STABLE_CYCLES (16),
        .RELEASE_GAP        (8),
        .REQUIRE_MSS_LOCK   (1'b1)
    ) dut_a (
        .FAB_CLK        (FAB_CLK),
        .M2F_RESET_N    (rst_n),
        .FAB_LOCK       (fab_lock),
        .MSS_LOCK       (mss_lock),
        .LOSS_CLR       (loss_clr),
        .CORE_RESET_N   (a_core),
        .PERIPH_RESET_N (a_periph),
        .CLK_READY      (a_ready),
        .LOCK_LOST      (a_lost),
        .LOSS_COUNT     (a_cnt)
    );

    ccc_lock_reset_seq #(
        .LOCK_STABLE_CYCLES (16),
        .RELEASE_GAP        (8),
        .REQUIRE_MSS_LOCK   (1'b0)
    ) dut_b (
        .FAB_CLK        (FAB_CLK),
        .M2F_RESET_N    (rst_n),
        .FAB_LOCK       (fab_lock),
        .MSS_LOCK       (mss_lock),
        .LOSS_CLR       (loss_clr),
        .CORE_RESET_N   (b_core),
        .PERIPH_RESET_N (b_periph),
        .CLK_READY      (b_ready),
        .LOCK_LOST      (b_lost),
        .LOSS_COUNT     (b_cnt)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge FAB_CLK);
        #1;
    endtask

    task automatic check_a(input string name, input logic core, input logic periph,
                           input logic ready, input logic lost, input logic [7:0] cnt);
        check({name, ".core"},   a_core,   core);
        check({name, ".periph"}, a_periph, periph);
        check({name, ".ready"},  a_ready,  ready);
        check({name, ".lost"},   a_lost,   lost);
        check({name, ".count"},  a_cnt,    cnt);
    endtask

    // Invariants, checked on every falling edge for both instances.
    always @(negedge FAB_CLK) begin
        check("inv_a_periph_implies_core", a_periph & ~a_core, 0);
        check("inv_a_ready_eq_periph",     a_ready,            a_periph);
        check("inv_b_periph_implies_core", b_periph & ~b_core, 0);
        check("inv_b_ready_eq_periph",     b_ready,            b_periph);
    end

    typedef struct {
        string      name;
        logic       rstn;
        logic       fab;
        logic       mss;
        logic       clr;
        int         ticks;
        logic       core;
        logic       periph;
        logic       ready;
        logic       lost;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string name, input logic rstn, input logic fab,
                                input logic mss, input logic clr, input int ticks,
                                input logic core, input logic periph, input logic ready,
                                input logic lost, input logic [7:0] cnt);
        vec_t v;
        v.name = name; v.rstn = rstn; v.fab = fab; v.mss = mss; v.clr = clr;
        v.ticks = ticks; v.core = core; v.periph = periph; v.ready = ready;
        v.lost = lost; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    initial begin
        int exp_cnt;

        rst_n    = 1'b0;
        fab_lock = 1'b0;
        mss_lock = 1'b0;
        loss_clr = 1'b0;

        //  name             rstn fab  mss  clr  ticks core per  rdy  lost cnt
        add("reset",         0,   0,   0,   0,   2,    0,   0,   0,   0,   0);
        // Both locks rise together; E0 is the first edge after this vector.
        add("e0",            1,   1,   1,   0,   1,    0,   0,   0,   0,   0);
        add("e0+17",         1,   1,   1,   0,   17,   0,   0,   0,   0,   0);
        add("e0+18_core",    1,   1,   1,   0,   1,    1,   0,   0,   0,   0);
        add("e0+25",         1,   1,   1,   0,   7,    1,   0,   0,   0,   0);
        add("e0+26_run",     1,   1,   1,   0,   1,    1,   1,   1,   0,   0);
        add("run_hold",      1,   1,   1,   0,   20,   1,   1,   1,   0,   0);
        // Loss in S_RUN: outputs still released at L0 and L0+1, drop at L0+2.
        add("l0",            1,   0,   1,   0,   1,    1,   1,   1,   0,   0);
        add("l0+1",          1,   0,   1,   0,   1,    1,   1,   1,   0,   0);
        add("l0+2_loss",     1,   0,   1,   0,   1,    0,   0,   0,   1,   1);
        add("requal_e0",     1,   1,   1,   0,   1,    0,   0,   0,   1,   1);
        add("requal+17",     1,   1,   1,   0,   17,   0,   0,   0,   1,   1);
        add("requal+18",     1,   1,   1,   0,   1,    1,   0,   0,   1,   1);
        add("requal+26",     1,   1,   1,   0,   8,    1,   1,   1,   1,   1);
        // Clear alone leaves the FSM and resets untouched.
        add("clr_in_run",    1,   1,   1,   1,   1,    1,   1,   1,   0,   0);
        add("loss2",         1,   0,   1,   0,   3,    0,   0,   0,   1,   1);
        add("clr_in_wait",   1,   0,   1,   1,   1,    0,   0,   0,   0,   0);
        // Glitch at qualification cycle 10 (S_QUAL entered at E0+2).
        add("glitch_e0",     1,   1,   1,   0,   1,    0,   0,   0,   0,   0);
        add("qual_cyc10",    1,   1,   1,   0,   11,   0,   0,   0,   0,   0);
        add("glitch_low",    1,   0,   1,   0,   3,    0,   0,   0,   0,   0);
        add("glitch_e0b",    1,   1,   1,   0,   1,    0,   0,   0,   0,   0);
        add("glitch+17",     1,   1,   1,   0,   17,   0,   0,   0,   0,   0);
        add("glitch+18",     1,   1,   1,   0,   1,    1,   0,   0,   0,   0);
        add("rel_core+2",    1,   1,   1,   0,   2,    1,   0,   0,   0,   0);
        // Reset in S_REL_CORE, then a full-latency restart.
        add("rst_mid",       0,   1,   1,   0,   1,    0,   0,   0,   0,   0);
        add("rst_e0",        1,   1,   1,   0,   1,    0,   0,   0,   0,   0);
        add("rst+17",        1,   1,   1,   0,   17,   0,   0,   0,   0,   0);
        add("rst+18",        1,   1,   1,   0,   1,    1,   0,   0,   0,   0);
        add("rst+25",        1,   1,   1,   0,   7,    1,   0,   0,   0,   0);
        add("rst+26",        1,   1,   1,   0,   1,    1,   1,   1,   0,   0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n    = vecs[i].rstn;
            fab_lock = vecs[i].fab;
            mss_lock = vecs[i].mss;
            loss_clr = vecs[i].clr;
            tick(vecs[i].ticks);
            check_a(vecs[i].name, vecs[i].core, vecs[i].periph, vecs[i].ready,
                    vecs[i].lost, vecs[i].cnt);
        end
        loss_clr = 1'b0;

        // MSS lock held low: dut_a never releases, dut_b releases normally.
        rst_n = 1'b0; fab_lock = 1'b0; mss_lock = 1'b0;
        tick(1);
        rst_n = 1'b1; fab_lock = 1'b1;
        tick(1);                                    // E0
        tick(17);
        check("nomss_b_core_e0+17", b_core, 0);
        tick(1);
        check("nomss_b_core_e0+18", b_core, 1);
        check("nomss_b_periph_e0+18", b_periph, 0);
        check("nomss_a_core_e0+18", a_core, 0);
        tick(7);
        check("nomss_b_periph_e0+25", b_periph, 0);
        tick(1);
        check("nomss_b_periph_e0+26", b_periph, 1);
        check("nomss_b_ready_e0+26", b_ready, 1);
        check("nomss_b_count", b_cnt, 0);
        check("nomss_a_periph_e0+26", a_periph, 0);
        tick(200);
        check("nomss_a_core_hold", a_core, 0);
        check("nomss_a_ready_hold", a_ready, 0);
        check("nomss_a_lost_hold", a_lost, 0);

        // 300 loss events on dut_a, each taken from S_REL_CORE.
        mss_lock = 1'b1;
        for (int i = 0; i < 300; i++) begin
            fab_lock = 1'b1;
            tick(19);                               // E0+18: core released
            check($sformatf("sat_core_up_%0d", i), a_core, 1);
            fab_lock = 1'b0;
            tick(3);                                // L0+2: event visible
            exp_cnt = (i + 1 > 255) ? 255 : i + 1;
            check($sformatf("sat_count_%0d", i), a_cnt, exp_cnt);
            check($sformatf("sat_lost_%0d", i), a_lost, 1);
            check($sformatf("sat_core_down_%0d", i), a_core, 0);
        end

        // Clear in the same cycle as a loss event.
        fab_lock = 1'b1;
        tick(19);
        check("sim_core_up", a_core, 1);
        fab_lock = 1'b0;
        tick(2);                                    // L0+1
        check("sim_count_before", a_cnt, 255);
        loss_clr = 1'b1;
        tick(1);                                    // L0+2, clear and event together
        loss_clr = 1'b0;
        check("sim_lost", a_lost, 1);
        check("sim_count", a_cnt, 1);
        check("sim_core_down", a_core, 0);

        // Reset clears the sticky loss tracking.
        rst_n = 1'b0;
        tick(1);
        check("rst_clears_lost", a_lost, 0);
        check("rst_clears_count", a_cnt, 0);
        rst_n = 1'b1;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ccc_lock_reset_seq
